fp_mul_norm_round: RTL and testbench

Normalization and rounding stage of the single-precision floating-point multiplier. It sits directly downstream of the 24x24 mantissa product calculator. It consumes the 48-bit raw mantissa product together with the sign, the exponent sum and the special-case flags from the unpack stage, and produces a packed IEEE-754 binary32 result. Rounding is round-to-nearest-even, subnormal results are flushed to zero, and the stage reports overflow, underflow and inexact status.

---
 rtl/fp_mul_norm_round.sv | 223 ++++++++++++++++++++++
 tb/tb_fp_mul_norm_round.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round: normalization and round-to-nearest-even stage of the
// binary32 multiplier. Captures the raw 48-bit mantissa product plus sign,
// exponent sum and special flags, then normalizes, rounds and packs over
// three further cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 level request; inputs captured when idle
//   product[47:0]         unsigned mantissa product, hidden bits included
//   sign                  result sign
//   exp_sum[9:0]          signed ea + eb - 127
//   is_nan/is_inf/is_zero special-case flags from unpack
//   result[31:0]          packed binary32 result (registered)
//   done                  result valid, held until start falls
//   overflow/underflow/inexact  IEEE status flags (registered)
module fp_mul_norm_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] product,
  input  logic        sign,
  input  logic [9:0]  exp_sum,
  input  logic        is_nan,
  input  logic        is_inf,
  input  logic        is_zero,
  output logic [31:0] result,
  output logic        done,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  localparam int unsigned PROD_W = 48;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned IE_W   = 11;
  localparam int unsigned MANT_W = 23;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NORM  = 3'd1,
    S_ROUND = 3'd2,
    S_PACK  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Captured operands
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;

  // Working mantissa / exponent / rounding bits
  logic [MANT_W-1:0]      mant_q, mant_d;
  logic signed [IE_W-1:0] e_q, e_d;
  logic                   g_q, g_d, s_q, s_d;
  logic                   zuf_q, zuf_d;

  // Registered outputs
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d, udf_q, udf_d, inx_q, inx_d;

  // Round-to-nearest-even increment and its carry-out
  logic          rnd_up;
  logic [MANT_W:0] mant_sum;
  assign rnd_up   = g_q & (s_q | mant_q[0]);
  assign mant_sum = {1'b0, mant_q} + (MANT_W+1)'(rnd_up);

  // Sign-extended exponent sum
  logic signed [IE_W-1:0] exp_ext;
  assign exp_ext = {exp_q[EXP_W-1], exp_q};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      prod_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      mant_q   <= '0;
      e_q      <= '0;
      g_q      <= 1'b0;
      s_q      <= 1'b0;
      zuf_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      nan_q    <= nan_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
      mant_q   <= mant_d;
      e_q      <= e_d;
      g_q      <= g_d;
      s_q      <= s_d;
      zuf_q    <= zuf_d;
      result_q <= result_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      inx_q    <= inx_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    nan_d    = nan_q;
    inf_d    = inf_q;
    zero_d   = zero_q;
    mant_d   = mant_q;
    e_d      = e_q;
    g_d      = g_q;
    s_d      = s_q;
    zuf_d    = zuf_q;
    result_d = result_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    inx_d    = inx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          prod_d  = product;
          exp_d   = exp_sum;
          sign_d  = sign;
          nan_d   = is_nan;
          inf_d   = is_inf;
          zero_d  = is_zero;
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        // Leading one at bit 47 or 46; neither means an unrepresentable tiny result
        zuf_d = ~prod_q[47] & ~prod_q[46];
        if (prod_q[47]) begin
          mant_d = prod_q[46:24];
          g_d    = prod_q[23];
          s_d    = |prod_q[22:0];
          e_d    = exp_ext + IE_W'(1);
        end else begin
          mant_d = prod_q[45:23];
          g_d    = prod_q[22];
          s_d    = |prod_q[21:0];
          e_d    = exp_ext;
        end
        state_d = S_ROUND;
      end

      S_ROUND: begin
        // Carry-out means the significand became 10.000..., i.e. 1.0 * 2
        if (mant_sum[MANT_W]) begin
          mant_d = '0;
          e_d    = e_q + IE_W'(1);
        end else begin
          mant_d = mant_sum[MANT_W-1:0];
        end
        state_d = S_PACK;
      end

      S_PACK: begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
        inx_d = 1'b0;
        if (nan_q) begin
          result_d = 32'h7FC0_0000;
        end else if (inf_q) begin
          result_d = {sign_q, 8'hFF, 23'd0};
        end else if (zero_q) begin
          result_d = {sign_q, 31'd0};
        end else if (zuf_q) begin
          result_d = {sign_q, 31'd0};
          udf_d    = 1'b1;
          inx_d    = |prod_q;
        end else if (e_q >= 11'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
          inx_d    = 1'b1;
        end else if (e_q <= 11'sd0) begin
          result_d = {sign_q, 31'd0};
          udf_d    = 1'b1;
          inx_d    = 1'b1;
        end else begin
          result_d = {sign_q, e_q[7:0], mant_q};
          inx_d    = g_q | s_q;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign result    = result_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Testbench for fp_mul_norm_round: directed vector table, handshake/reset
// sequences, and random operations checked against an arithmetic model.
module tb_fp_mul_norm_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [47:0] product;
  logic        sign;
  logic [9:0]  exp_sum;
  logic        is_nan, is_inf, is_zero;
  logic [31:0] result;
  logic        done, overflow, underflow, inexact;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_mul_norm_round dut (
    .clk(clk), .rst_n(rst_n), .start(start), .product(product), .sign(sign),
    .exp_sum(exp_sum), .is_nan(is_nan), .is_inf(is_inf), .is_zero(is_zero),
    .result(result), .done(done), .overflow(overflow), .underflow(underflow),
    .inexact(inexact)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        udf;
    logic        inx;
    logic        chk_inx;
  } exp_t;

  typedef struct {
    logic [47:0] p;
    logic [9:0]  es;
    logic        s;
    logic        nan;
    logic        inf;
    logic        zero;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Reference: binary32 product from the raw significand product by plain arithmetic
  function automatic exp_t model(input logic [47:0] p, input logic signed [9:0] es,
                                 input logic s, input logic nan, input logic inf,
                                 input logic zero);
    exp_t r;
    longint unsigned prod, q, rem, half;
    int sh, e;
    prod = 64'(p);
    r = '{res: 32'd0, ovf: 1'b0, udf: 1'b0, inx: 1'b0, chk_inx: 1'b1};
    if (nan) begin r.res = 32'h7FC00000; return r; end
    if (inf) begin r.res = {s, 8'hFF, 23'd0}; return r; end
    if (zero) begin r.res = {s, 31'd0}; return r; end
    if (prod < (64'd1 << 46)) begin
      r.res = {s, 31'd0}; r.udf = 1'b1; r.chk_inx = 1'b0; return r;
    end
    sh   = (prod >= (64'd1 << 47)) ? 24 : 23;
    e    = int'(es) + ((sh == 24) ? 1 : 0);
    q    = prod >> sh;
    rem  = prod - (q << sh);
    half = 64'd1 << (sh - 1);
    r.inx = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
    if (e >= 255) begin
      r.res = {s, 8'hFF, 23'd0}; r.ovf = 1'b1; r.inx = 1'b1;
    end else if (e <= 0) begin
      r.res = {s, 31'd0}; r.udf = 1'b1; r.inx = 1'b1;
    end else begin
      r.res = {s, 8'(e), 23'(q)};
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [47:0] p, input logic [9:0] es, input logic s,
                              input logic nan, input logic inf, input logic zero,
                              input logic [31:0] res, input logic ovf, input logic udf,
                              input logic inx, input logic chk_inx);
    vec_t v;
    v.p = p; v.es = es; v.s = s; v.nan = nan; v.inf = inf; v.zero = zero;
    v.e = '{res: res, ovf: ovf, udf: udf, inx: inx, chk_inx: chk_inx};
    return v;
  endfunction

  task automatic scramble_inputs();
    product = {16'($urandom), $urandom};
    exp_sum = 10'($urandom);
    sign    = 1'($urandom);
    is_nan  = 1'($urandom);
    is_inf  = 1'($urandom);
    is_zero = 1'($urandom);
  endtask

  // One full operation: capture, latency, result/flags, hold, release
  task automatic run_op(input vec_t v, input string tag, input bit drop_early, input int hold);
    int cyc;
    logic [31:0] r0;
    bit stable;
    bit hold_ok;
    @(negedge clk);
    product = v.p; exp_sum = v.es; sign = v.s;
    is_nan = v.nan; is_inf = v.inf; is_zero = v.zero;
    start = 1'b1;
    @(posedge clk);
    #1;
    r0 = result;
    stable = 1'b1;
    scramble_inputs();
    if (drop_early) start = 1'b0;
    cyc = 0;
    while (!done && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!done && result !== r0) stable = 1'b0;
    end
    chk({tag, " latency"}, 32'(cyc), 32'd3);
    chk({tag, " result"}, result, v.e.res);
    chk({tag, " overflow"}, 32'(overflow), 32'(v.e.ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(v.e.udf));
    if (v.e.chk_inx) chk({tag, " inexact"}, 32'(inexact), 32'(v.e.inx));
    chk({tag, " no_toggle"}, 32'(stable), 32'd1);
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      scramble_inputs();
      @(posedge clk);
      #1;
      if (done !== 1'b1 || result !== v.e.res) hold_ok = 1'b0;
    end
    if (hold > 0) chk({tag, " hold_no_recapture"}, 32'(hold_ok), 32'd1);
    if (!drop_early) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, " done_clear"}, 32'(done), 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    exp_t m;
    bit quiet;

    tbl.push_back(mk(48'h400000000000, 10'd127, 0, 0, 0, 0, 32'h3F800000, 0, 0, 0, 1));
    tbl.push_back(mk(48'h900000000000, 10'd127, 0, 0, 0, 0, 32'h40100000, 0, 0, 0, 1));
    tbl.push_back(mk(48'h900000000000, 10'd127, 1, 0, 0, 0, 32'hC0100000, 0, 0, 0, 1));
    tbl.push_back(mk(48'h400000400000, 10'd127, 0, 0, 0, 0, 32'h3F800000, 0, 0, 1, 1));
    tbl.push_back(mk(48'h400000C00000, 10'd127, 0, 0, 0, 0, 32'h3F800002, 0, 0, 1, 1));
    tbl.push_back(mk(48'h7FFFFFFFFFFF, 10'd127, 0, 0, 0, 0, 32'h40000000, 0, 0, 1, 1));
    tbl.push_back(mk(48'h800000000000, 10'd254, 0, 0, 0, 0, 32'h7F800000, 1, 0, 1, 1));
    tbl.push_back(mk(48'h800000000000, 10'd253, 0, 0, 0, 0, 32'h7F000000, 0, 0, 0, 1));
    tbl.push_back(mk(48'h7FFFFFFFFFFF, 10'd254, 0, 0, 0, 0, 32'h7F800000, 1, 0, 1, 1));
    tbl.push_back(mk(48'h400000000000, 10'd0,   1, 0, 0, 0, 32'h80000000, 0, 1, 1, 1));
    tbl.push_back(mk(48'h800000000000, 10'h3FF, 0, 0, 0, 0, 32'h00000000, 0, 1, 1, 1));
    tbl.push_back(mk(48'h400000000000, 10'd1,   0, 0, 0, 0, 32'h00800000, 0, 0, 0, 1));
    tbl.push_back(mk(48'h400000000000, 10'h3CE, 0, 0, 0, 0, 32'h00000000, 0, 1, 1, 1));
    tbl.push_back(mk(48'h400000000000, 10'd127, 0, 1, 1, 0, 32'h7FC00000, 0, 0, 0, 1));
    tbl.push_back(mk(48'h400000000000, 10'd127, 1, 0, 1, 0, 32'hFF800000, 0, 0, 0, 1));
    tbl.push_back(mk(48'h400000000000, 10'd127, 0, 0, 0, 1, 32'h00000000, 0, 0, 0, 1));
    tbl.push_back(mk(48'h000000000001, 10'd127, 1, 0, 0, 0, 32'h80000000, 0, 1, 0, 0));

    rst_n = 1'b0; start = 1'b0;
    product = '0; exp_sum = '0; sign = 1'b0;
    is_nan = 1'b0; is_inf = 1'b0; is_zero = 1'b0;
    #12;
    chk("reset result", result, 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset flags", 32'({overflow, underflow, inexact}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i), 1'b0, 0);

    // start held high past done
    run_op(tbl[1], "hold", 1'b0, 10);
    // start dropped mid-operation: done lasts exactly one cycle
    run_op(tbl[4], "early_drop", 1'b1, 0);

    // reset pulsed while in ROUND
    @(negedge clk);
    product = 48'h900000000000; exp_sum = 10'd127; sign = 1'b1;
    is_nan = 1'b0; is_inf = 1'b0; is_zero = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst result", result, 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst flags", 32'({overflow, underflow, inexact}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || result !== 32'd0) quiet = 1'b0;
    end
    chk("midrst quiet", 32'(quiet), 32'd1);
    run_op(tbl[2], "after_rst", 1'b0, 0);

    // random operations against the model
    for (int n = 0; n < 300; n++) begin
      v.p = {16'($urandom), $urandom};
      case ($urandom_range(0, 4))
        0: v.p[47] = 1'b1;
        1: v.p[47:46] = 2'b01;
        2: begin v.p[47:46] = 2'b01; v.p[21:0] = '0; end
        3: begin v.p[47] = 1'b1; v.p[22:0] = '0; end
        default: ;
      endcase
      v.es   = 10'(int'($urandom_range(0, 420)) - 100);
      v.s    = 1'($urandom);
      v.nan  = ($urandom_range(0, 15) == 0);
      v.inf  = ($urandom_range(0, 15) == 0);
      v.zero = ($urandom_range(0, 15) == 0);
      m = model(v.p, v.es, v.s, v.nan, v.inf, v.zero);
      v.e = m;
      run_op(v, $sformatf("rnd%0d", n), 1'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
